// File: rtl/blink_monitor_pkg.sv
// rtl/blink_monitor_pkg.sv - shared definitions for the blink monitor
// Purpose: state encodings, default counter width and counter saturation
//          constant shared by blink_monitor and its bench.
// Ports:   none (package).
// Config:  BLINK_MONITOR_GLITCH_FILTER_EN is consumed by blink_sync_edge.
package blink_monitor_pkg;

  localparam int CNT_W_DEF = 16;

  localparam logic [CNT_W_DEF-1:0] CNT_SAT_DEF = {CNT_W_DEF{1'b1}};

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ARM       = 3'd1;
  localparam logic [2:0] ST_MEAS_HIGH = 3'd2;
  localparam logic [2:0] ST_MEAS_LOW  = 3'd3;
  localparam logic [2:0] ST_DONE      = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_ARM       = ST_ARM,
    S_MEAS_HIGH = ST_MEAS_HIGH,
    S_MEAS_LOW  = ST_MEAS_LOW,
    S_DONE      = ST_DONE
  } state_t;

endpackage

// File: rtl/blink_sync_edge.sv
// rtl/blink_sync_edge.sv - pad synchronizer, optional glitch filter, edge strobes
// Purpose: brings the asynchronous blink pad into the clock domain and emits
//          one-cycle rise/fall strobes, SYNC_STAGES+1 cycles after a pad edge.
// Ports:   i_clk, i_rst (sync active-high), i_sig (async pad),
//          o_rise / o_fall (registered single-cycle strobes).
// Config:  BLINK_MONITOR_GLITCH_FILTER_EN adds a 3-sample majority filter
//          (+2 cycles strobe latency, single-cycle glitches rejected).
module blink_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sig,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_level;
  logic                   r_prev;
  logic                   r_rise;
  logic                   r_fall;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_sync <= '0;
    else       r_sync <= {r_sync[SYNC_STAGES-2:0], i_sig};
  end

`ifdef BLINK_MONITOR_GLITCH_FILTER_EN
  logic r_h1;
  logic r_h2;
  logic r_filt;
  logic w_s;

  assign w_s = r_sync[SYNC_STAGES-1];

  // Majority of the current and two previous samples; registering the vote
  // gives a fixed 2-cycle delay, so clean phase lengths are preserved.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_h1   <= 1'b0;
      r_h2   <= 1'b0;
      r_filt <= 1'b0;
    end else begin
      r_h1   <= w_s;
      r_h2   <= r_h1;
      r_filt <= (w_s & r_h1) | (w_s & r_h2) | (r_h1 & r_h2);
    end
  end

  assign w_level = r_filt;
`else
  assign w_level = r_sync[SYNC_STAGES-1];
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prev <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_prev <= w_level;
      r_rise <= w_level & ~r_prev;
      r_fall <= ~w_level & r_prev;
    end
  end

  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/blink_monitor.sv
// rtl/blink_monitor.sv - square-wave blink receiver and period checker
// Purpose: measures each high/low phase of sig_i, compares against
//          exp_high/exp_low within tol, counts good/bad periods until target.
// Ports:   wb_clk_i, wb_rst_i (sync active-high), en (rise starts a run),
//          sig_i (async pad), exp_high, exp_low, tol, target (0 acts as 1),
//          busy, done, pass, good_cnt, fail_cnt, last_high, last_low.
// Config:  BLINK_MONITOR_GLITCH_FILTER_EN (see blink_sync_edge).
module blink_monitor
  import blink_monitor_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             en,
  input  logic             sig_i,
  input  logic [CNT_W-1:0] exp_high,
  input  logic [CNT_W-1:0] exp_low,
  input  logic [3:0]       tol,
  input  logic [7:0]       target,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       good_cnt,
  output logic [7:0]       fail_cnt,
  output logic [CNT_W-1:0] last_high,
  output logic [CNT_W-1:0] last_low
);

  localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_last_high, w_last_high_nxt;
  logic [CNT_W-1:0] r_last_low, w_last_low_nxt;
  logic [7:0]       r_good, w_good_nxt;
  logic [7:0]       r_fail, w_fail_nxt;
  logic             r_en_d;

  logic             w_rise, w_fall, w_en_rise;
  logic             w_busy, w_done, w_pass;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [CNT_W:0]   w_tol_ext, w_lim_high, w_lim_low, w_dev_high, w_dev_low;
  logic             w_to_high, w_to_low, w_ok;
  logic [CNT_W-1:0] w_to_val_high, w_to_val_low;
  logic [7:0]       w_good_inc, w_fail_inc, w_target;
  logic             w_reach_good, w_reach_fail;

  blink_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_edge (
    .i_clk  (wb_clk_i),
    .i_rst  (wb_rst_i),
    .i_sig  (sig_i),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  assign w_en_rise = en & ~r_en_d;
  assign w_cnt_inc = (r_cnt == CNT_SAT) ? r_cnt : r_cnt + CNT_ONE;

  // Limits and deviations are one bit wider than the counter so exp+tol
  // and the subtraction never wrap.
  assign w_tol_ext  = {{(CNT_W-3){1'b0}}, tol};
  assign w_lim_high = {1'b0, exp_high} + w_tol_ext;
  assign w_lim_low  = {1'b0, exp_low}  + w_tol_ext;

  // A saturated counter counts as a timeout so exp+tol beyond the counter
  // range still ends a stuck phase.
  assign w_to_high = ({1'b0, r_cnt} > w_lim_high) || (r_cnt == CNT_SAT);
  assign w_to_low  = ({1'b0, r_cnt} > w_lim_low)  || (r_cnt == CNT_SAT);

  assign w_to_val_high = (w_lim_high >= {1'b0, CNT_SAT}) ? CNT_SAT : w_lim_high[CNT_W-1:0] + CNT_ONE;
  assign w_to_val_low  = (w_lim_low  >= {1'b0, CNT_SAT}) ? CNT_SAT : w_lim_low[CNT_W-1:0]  + CNT_ONE;

  assign w_dev_high = (r_last_high >= exp_high) ? {1'b0, r_last_high} - {1'b0, exp_high}
                                                : {1'b0, exp_high} - {1'b0, r_last_high};
  assign w_dev_low  = (r_cnt >= exp_low) ? {1'b0, r_cnt} - {1'b0, exp_low}
                                         : {1'b0, exp_low} - {1'b0, r_cnt};
  assign w_ok = (w_dev_high <= w_tol_ext) && (w_dev_low <= w_tol_ext);

  assign w_good_inc = (r_good == 8'hFF) ? r_good : r_good + 8'd1;
  assign w_fail_inc = (r_fail == 8'hFF) ? r_fail : r_fail + 8'd1;
  assign w_target   = (target == 8'd0) ? 8'd1 : target;

  // Completion looks at the counts including this cycle's evaluation.
  assign w_reach_good = ({1'b0, w_good_inc} + {1'b0, r_fail}) >= {1'b0, w_target};
  assign w_reach_fail = ({1'b0, r_good} + {1'b0, w_fail_inc}) >= {1'b0, w_target};

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_last_high_nxt = r_last_high;
    w_last_low_nxt  = r_last_low;
    w_good_nxt      = r_good;
    w_fail_nxt      = r_fail;
    w_busy          = 1'b0;
    w_done          = 1'b0;
    w_pass          = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_en_rise) begin
          w_good_nxt      = '0;
          w_fail_nxt      = '0;
          w_last_high_nxt = '0;
          w_last_low_nxt  = '0;
          w_cnt_nxt       = '0;
          w_state_nxt     = S_ARM;
        end
      end
      S_ARM: begin
        w_busy = 1'b1;
        if (!en) begin
          w_state_nxt = S_IDLE;
        end else if (w_rise) begin
          w_cnt_nxt   = CNT_ONE;
          w_state_nxt = S_MEAS_HIGH;
        end
      end
      S_MEAS_HIGH: begin
        w_busy = 1'b1;
        if (!en) begin
          w_state_nxt = S_IDLE;
        end else if (w_fall) begin
          w_last_high_nxt = r_cnt;
          w_cnt_nxt       = CNT_ONE;
          w_state_nxt     = S_MEAS_LOW;
        end else if (w_to_high) begin
          w_fail_nxt      = w_fail_inc;
          w_last_high_nxt = w_to_val_high;
          w_cnt_nxt       = '0;
          w_state_nxt     = w_reach_fail ? S_DONE : S_ARM;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      S_MEAS_LOW: begin
        w_busy = 1'b1;
        if (!en) begin
          w_state_nxt = S_IDLE;
        end else if (w_rise) begin
          // This rise closes the period and also opens the next one.
          w_last_low_nxt = r_cnt;
          w_cnt_nxt      = CNT_ONE;
          if (w_ok) begin
            w_good_nxt  = w_good_inc;
            w_state_nxt = w_reach_good ? S_DONE : S_MEAS_HIGH;
          end else begin
            w_fail_nxt  = w_fail_inc;
            w_state_nxt = w_reach_fail ? S_DONE : S_MEAS_HIGH;
          end
        end else if (w_to_low) begin
          w_fail_nxt     = w_fail_inc;
          w_last_low_nxt = w_to_val_low;
          w_cnt_nxt      = '0;
          w_state_nxt    = w_reach_fail ? S_DONE : S_ARM;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      S_DONE: begin
        w_done = 1'b1;
        w_pass = (r_fail == 8'd0);
        if (!en) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_last_high <= '0;
      r_last_low  <= '0;
      r_good      <= '0;
      r_fail      <= '0;
      // Treat en as already high so a level held through reset cannot
      // start a run; only a fresh rise does.
      r_en_d      <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_last_high <= w_last_high_nxt;
      r_last_low  <= w_last_low_nxt;
      r_good      <= w_good_nxt;
      r_fail      <= w_fail_nxt;
      r_en_d      <= en;
    end
  end

  assign busy      = w_busy;
  assign done      = w_done;
  assign pass      = w_pass;
  assign good_cnt  = r_good;
  assign fail_cnt  = r_fail;
  assign last_high = r_last_high;
  assign last_low  = r_last_low;

endmodule

// File: tb/tb_blink_monitor.sv
// tb/tb_blink_monitor.sv - directed self-checking bench for blink_monitor
module tb_blink_monitor;

`ifdef BLINK_MONITOR_GLITCH_FILTER_EN
  localparam int FLT = 2;
`else
  localparam int FLT = 0;
`endif

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        en;
  logic        sig_i;
  logic [15:0] exp_high;
  logic [15:0] exp_low;
  logic [3:0]  tol;
  logic [7:0]  target;
  logic        busy;
  logic        done;
  logic        pass;
  logic [7:0]  good_cnt;
  logic [7:0]  fail_cnt;
  logic [15:0] last_high;
  logic [15:0] last_low;

  int n_checks = 0;
  int n_fail   = 0;

  blink_monitor #(.CNT_W(16), .SYNC_STAGES(2)) dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .en        (en),
    .sig_i     (sig_i),
    .exp_high  (exp_high),
    .exp_low   (exp_low),
    .tol       (tol),
    .target    (target),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .good_cnt  (good_cnt),
    .fail_cnt  (fail_cnt),
    .last_high (last_high),
    .last_low  (last_low)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input int n);
    sig_i = v;
    repeat (n) @(negedge wb_clk_i);
  endtask

  task automatic square(input int n, input int lo, input int bad_idx, input int bad_h);
    for (int i = 1; i <= n; i++) begin
      drive(1'b1, (i == bad_idx) ? bad_h : 4);
      drive(1'b0, lo);
    end
  endtask

  task automatic restart(input int eh, input int el, input int t, input int tg);
    en       = 1'b0;
    sig_i    = 1'b0;
    exp_high = 16'(eh);
    exp_low  = 16'(el);
    tol      = 4'(t);
    target   = 8'(tg);
    repeat (3) @(negedge wb_clk_i);
    en = 1'b1;
    repeat (2) @(negedge wb_clk_i);
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (!done && k < 200) begin
      @(negedge wb_clk_i);
      k++;
    end
    check(tag, done, 1);
  endtask

  initial begin
    wb_rst_i = 1'b1;
    en       = 1'b0;
    sig_i    = 1'b0;
    exp_high = 16'd4;
    exp_low  = 16'd4;
    tol      = 4'd0;
    target   = 8'd50;
    repeat (3) @(negedge wb_clk_i);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_good", good_cnt, 0);
    check("rst_fail", fail_cnt, 0);
    check("rst_lhigh", last_high, 0);
    check("rst_llow", last_low, 0);
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);

    // Clean 4/4 run, 50 periods
    restart(4, 4, 0, 50);
    check("clean_busy", busy, 1);
    square(51, 4, 0, 0);
    drive(1'b0, 6);
    wait_done("clean_done");
    check("clean_pass", pass, 1);
    check("clean_good", good_cnt, 50);
    check("clean_fail", fail_cnt, 0);
    check("clean_lhigh", last_high, 4);
    check("clean_llow", last_low, 4);
    check("clean_busy_end", busy, 0);
    en = 1'b0;
    repeat (2) @(negedge wb_clk_i);
    check("clean_off_done", done, 0);
    check("clean_off_pass", pass, 0);
    check("clean_off_good", good_cnt, 50);

    // Period 10 with a 5-cycle high, tol 0
    restart(4, 4, 0, 50);
    square(51, 4, 10, 5);
    drive(1'b0, 6);
    wait_done("dist_done");
    check("dist_pass", pass, 0);
    check("dist_good", good_cnt, 49);
    check("dist_fail", fail_cnt, 1);

    // Same distortion absorbed by tol 1
    restart(4, 4, 1, 50);
    square(51, 4, 10, 5);
    drive(1'b0, 6);
    wait_done("tol_done");
    check("tol_pass", pass, 1);
    check("tol_good", good_cnt, 50);

    // Stuck high: timeout exactly 5 cycles after the rise strobe
    restart(4, 4, 0, 50);
    sig_i = 1'b1;
    repeat (8 + FLT) @(negedge wb_clk_i);
    check("stuck_pre_fail", fail_cnt, 0);
    @(negedge wb_clk_i);
    check("stuck_fail", fail_cnt, 1);
    check("stuck_lhigh", last_high, 5);
    check("stuck_busy", busy, 1);
    check("stuck_good", good_cnt, 0);
    repeat (20) @(negedge wb_clk_i);
    check("stuck_armed_fail", fail_cnt, 1);

    // Abort in MEAS_LOW, then restart
    restart(4, 8, 0, 50);
    square(3, 8, 0, 0);
    drive(1'b1, 4);
    drive(1'b0, 5 + FLT);
    en = 1'b0;
    repeat (2) @(negedge wb_clk_i);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_good", good_cnt, 3);
    check("abort_fail", fail_cnt, 0);
    check("abort_llow", last_low, 8);
    en = 1'b1;
    repeat (2) @(negedge wb_clk_i);
    check("rearm_busy", busy, 1);
    check("rearm_good", good_cnt, 0);
    check("rearm_llow", last_low, 0);

    // Reset pulse during MEAS_HIGH with en held high
    restart(4, 4, 0, 50);
    square(2, 4, 0, 0);
    sig_i = 1'b1;
    repeat (5 + FLT) @(negedge wb_clk_i);
    check("prerst_good", good_cnt, 2);
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_good", good_cnt, 0);
    check("midrst_lhigh", last_high, 4'd0);
    check("midrst_llow", last_low, 0);
    drive(1'b0, 4);
    square(3, 4, 0, 0);
    check("postrst_busy", busy, 0);
    check("postrst_good", good_cnt, 0);
    check("postrst_fail", fail_cnt, 0);

    // target 0 behaves as 1
    restart(4, 4, 0, 0);
    square(2, 4, 0, 0);
    wait_done("t0_done");
    check("t0_good", good_cnt, 1);
    check("t0_pass", pass, 1);

    // One-cycle high glitch inside a low phase
    restart(4, 4, 0, 3);
    drive(1'b1, 4); drive(1'b0, 4);
    drive(1'b1, 4); drive(1'b0, 1); drive(1'b1, 1); drive(1'b0, 2);
    square(3, 4, 0, 0);
    drive(1'b0, 6);
    wait_done("glitch_done");
`ifdef BLINK_MONITOR_GLITCH_FILTER_EN
    check("glitch_fail", fail_cnt, 0);
    check("glitch_good", good_cnt, 3);
`else
    check("glitch_fail_nz", 32'(fail_cnt != 8'd0), 1);
    check("glitch_fail", fail_cnt, 2);
`endif
    en = 1'b0;
    repeat (2) @(negedge wb_clk_i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
